// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame-engine state encoding, default frame geometry, width helper.
// Used by the SPI master, its arbiter and any sibling SPI blocks.
package spi_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_CLK_DIV    = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    GAP
  } spi_state_e;

  // Index width that stays legal (>=1 bit) even for a single-entry range.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_master_if.sv
// Client/SPI-side bundle of the round-robin SPI master; master = the engine, slave = clients + SPI device.
// Requests are level-held; grant/done close the handshake, there is no other backpressure.
interface spi_rr_master_if #(
  parameter int NREQ       = 4,
  parameter int FRAME_BITS = 16
);

  logic [NREQ-1:0]            req;
  logic [NREQ*FRAME_BITS-1:0] tx_data;
  logic [NREQ-1:0]            gnt;
  logic [NREQ-1:0]            done;
  logic [FRAME_BITS-1:0]      rx_data;
  logic                       busy;
  logic                       cs;
  logic                       dclk;
  logic                       mosi;
  logic                       miso;
  logic [$clog2(FRAME_BITS)-1:0] cnt;

  modport master (
    input  req, tx_data, miso,
    output gnt, done, rx_data, busy, cs, dclk, mosi, cnt
  );

  modport slave (
    output req, tx_data, miso,
    input  gnt, done, rx_data, busy, cs, dclk, mosi, cnt
  );

endinterface

// File: rtl/spi_rr_master_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
// Zero latency; an all-zero request vector yields an all-zero one-hot.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = cw(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [IW-1:0]   gnt_idx_o
);

  logic found;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      logic [IW-1:0] jj;
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!found && req_i[jj]) begin
        found         = 1'b1;
        gnt_oh_o[jj]  = 1'b1;
        gnt_idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/spi_rr_master.sv
// Round-robin SPI master: grants one requester per fixed-length full-duplex frame, dclk idle-high, MSB first.
// Grant one edge after req seen in IDLE; cs low (2*FRAME_BITS+1)*CLK_DIV cycles; cs high GAP_CYC cycles between frames.
module spi_rr_master
  import spi_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int FRAME_BITS = SPI_FRAME_BITS,
  parameter int CLK_DIV    = SPI_CLK_DIV,
  parameter int GAP_CYC    = 4
) (
  input logic             clk,
  input logic             rst_n,
  spi_rr_master_if.master bus
);

  localparam int IW   = cw(NREQ);
  localparam int CW   = $clog2(FRAME_BITS);
  localparam int TMAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int TW   = cw(TMAX);

  localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);
  // The IDLE cycle is part of the inter-frame cs-high window, so GAP itself runs one cycle short.
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYC >= 2) ? GAP_CYC - 2 : 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  spi_state_e            state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         win_q, win_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [NREQ-1:0]       done_q, done_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [FRAME_BITS-1:0] txsh_q, txsh_d;
  logic [FRAME_BITS-1:0] rxsh_q, rxsh_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  cs_q, cs_d;
  logic                  dclk_q, dclk_d;
  logic                  mosi_q, mosi_d;

  logic [NREQ-1:0]       arb_oh;
  logic [IW-1:0]         arb_idx;
  logic [FRAME_BITS-1:0] tx_sel;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx)
  );

  always_comb begin
    tx_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_oh[i]) tx_sel = bus.tx_data[i*FRAME_BITS +: FRAME_BITS];
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rx_d    = rx_q;
    txsh_d  = txsh_q;
    rxsh_d  = rxsh_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    busy_d  = busy_q;
    cs_d    = cs_q;
    dclk_d  = dclk_q;
    mosi_d  = mosi_q;

    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (|bus.req) begin
          gnt_d   = arb_oh;
          win_d   = arb_idx;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          dclk_d  = 1'b1;
          txsh_d  = tx_sel;
          mosi_d  = tx_sel[FRAME_BITS-1];
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (tmr_q == DIV_LAST) begin
          tmr_d   = '0;
          dclk_d  = 1'b0;
          state_d = LOW;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      LOW: begin
        if (tmr_q == DIV_LAST) begin
          tmr_d   = '0;
          dclk_d  = 1'b1;
          rxsh_d  = {rxsh_q[FRAME_BITS-2:0], bus.miso};
          cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
          last_d  = (cnt_q == CNT_LAST);
          state_d = HIGH;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      HIGH: begin
        if (tmr_q == DIV_LAST) begin
          tmr_d = '0;
          if (last_q) begin
            cs_d   = 1'b1;
            done_d = gnt_q;
            rx_d   = rxsh_q;
            gnt_d  = '0;
            ptr_d  = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
            mosi_d = 1'b0;
            if (GAP_CYC == 1) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = GAP;
            end
          end else begin
            dclk_d  = 1'b0;
            mosi_d  = txsh_q[FRAME_BITS-2];
            txsh_d  = txsh_q << 1;
            state_d = LOW;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rx_q    <= '0;
      txsh_q  <= '0;
      rxsh_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b1;
      dclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
      txsh_q  <= txsh_d;
      rxsh_q  <= rxsh_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      dclk_q  <= dclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;
  assign bus.busy    = busy_q;
  assign bus.cs      = cs_q;
  assign bus.dclk    = dclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cnt     = cnt_q;

  a_dclk_idle: assert property (@(posedge clk) disable iff (!rst_n) bus.cs |-> bus.dclk);
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.gnt));

endmodule

// File: tb/tb_spi_rr_master.sv
// Directed bench for spi_rr_master: frame shape, round-robin order, async reset, mid-frame req changes.
module tb_spi_rr_master;

  localparam int NREQ = 4;
  localparam int FB   = 16;
  localparam int CW   = $clog2(FB);

  logic clk = 1'b0;
  logic rst_n;
  int   miso_mode;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  spi_rr_master_if #(.NREQ(NREQ), .FRAME_BITS(FB)) bus ();

  spi_rr_master #(
    .NREQ       (NREQ),
    .FRAME_BITS (FB),
    .CLK_DIV    (2),
    .GAP_CYC    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // 0: miso tied low, 1: tied high, 2: looped back from mosi
  assign bus.miso = (miso_mode == 2) ? bus.mosi : (miso_mode == 1);

  logic [NREQ-1:0] f_gnt, f_done, f_done_after, f_gnt_end;
  logic [FB-1:0]   f_mosi, f_rx;
  logic [CW-1:0]   f_cnt_end;
  int              f_cs_low, f_rises, f_pre, f_busy_low;
  bit              f_timeout, f_idle_ok, f_gnt_ok, f_cnt_ok;

  // Observes one frame from the current negedge through one cycle past done.
  task automatic capture(input int mid_cyc, input logic [NREQ-1:0] mid_clr,
                         input logic [NREQ-1:0] mid_set, input logic [NREQ-1:0] end_clr);
    logic prev_dclk;
    f_timeout = 0; f_pre = 0; f_busy_low = 0; f_idle_ok = 1; f_gnt_ok = 1; f_cnt_ok = 1;
    f_cs_low = 0; f_rises = 0; f_mosi = '0; f_gnt = '0;
    while (bus.cs === 1'b1 && f_pre < 40) begin
      if (bus.dclk !== 1'b1) f_idle_ok = 0;
      if (bus.busy === 1'b0) f_busy_low++;
      f_pre++;
      @(negedge clk);
    end
    if (f_pre >= 40) begin f_timeout = 1; return; end
    f_gnt     = bus.gnt;
    prev_dclk = bus.dclk;
    while (bus.cs === 1'b0 && f_cs_low < 200) begin
      f_cs_low++;
      if (bus.gnt !== f_gnt) f_gnt_ok = 0;
      if (f_cs_low == mid_cyc) bus.req = (bus.req & ~mid_clr) | mid_set;
      if (bus.dclk === 1'b1 && prev_dclk === 1'b0) begin
        f_rises++;
        f_mosi = {f_mosi[FB-2:0], bus.mosi};
      end
      if (bus.cnt !== CW'(f_rises % FB)) f_cnt_ok = 0;
      prev_dclk = bus.dclk;
      @(negedge clk);
    end
    if (f_cs_low >= 200) begin f_timeout = 1; return; end
    f_done    = bus.done;
    f_rx      = bus.rx_data;
    f_gnt_end = bus.gnt;
    f_cnt_end = bus.cnt;
    bus.req   = bus.req & ~end_clr;
    @(negedge clk);
    f_done_after = bus.done;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; bus.req = '0; bus.tx_data = '0; miso_mode = 0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({bus.cs, bus.dclk, bus.mosi} !== 3'b110) $display("FAIL reset_pins: got %b want 110", {bus.cs, bus.dclk, bus.mosi}); else passes++;
    checks++; if ({bus.gnt, bus.done, bus.busy} !== 9'd0) $display("FAIL reset_ctl: got %b want 0", {bus.gnt, bus.done, bus.busy}); else passes++;
    checks++; if ({bus.rx_data, bus.cnt} !== 20'd0) $display("FAIL reset_data: got %h want 0", {bus.rx_data, bus.cnt}); else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    miso_mode = 2;
    bus.tx_data[0 +: FB] = 16'hA5C3;
    bus.req = 4'b0001;
    capture(0, '0, '0, 4'b0001);
    checks++; if (f_timeout !== 1'b0) $display("FAIL single_timeout: got %0d want 0", f_timeout); else passes++;
    checks++; if (f_cs_low !== 66) $display("FAIL single_cs_low: got %0d want 66", f_cs_low); else passes++;
    checks++; if (f_rises !== 16) $display("FAIL single_rises: got %0d want 16", f_rises); else passes++;
    checks++; if (f_mosi !== 16'hA5C3) $display("FAIL single_mosi: got %h want a5c3", f_mosi); else passes++;
    checks++; if (f_gnt !== 4'b0001 || f_gnt_ok !== 1'b1) $display("FAIL single_gnt: got %b stable %0d want 0001 stable 1", f_gnt, f_gnt_ok); else passes++;
    checks++; if (f_done !== 4'b0001 || f_done_after !== 4'b0000) $display("FAIL single_done: got %b then %b want 0001 then 0000", f_done, f_done_after); else passes++;
    checks++; if (f_rx !== 16'hA5C3) $display("FAIL single_rx: got %h want a5c3", f_rx); else passes++;
    checks++; if (f_gnt_end !== 4'b0000) $display("FAIL single_gnt_end: got %b want 0000", f_gnt_end); else passes++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_all_four();
    logic [FB-1:0] tx [NREQ];
    do_reset();
    miso_mode = 2;
    for (int i = 0; i < NREQ; i++) begin
      tx[i] = 16'h1234 + FB'(i * 16'h1111);
      bus.tx_data[i*FB +: FB] = tx[i];
    end
    bus.req = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      logic [NREQ-1:0] exp_g;
      exp_g = 4'b0001 << k;
      capture(0, '0, '0, exp_g);
      checks++; if (f_timeout !== 1'b0 || f_gnt !== exp_g) $display("FAIL all4_gnt%0d: got %b want %b", k, f_gnt, exp_g); else passes++;
      checks++; if (f_done !== exp_g || f_done_after !== 4'b0000) $display("FAIL all4_done%0d: got %b then %b want %b then 0000", k, f_done, f_done_after, exp_g); else passes++;
      checks++; if (f_rx !== tx[k]) $display("FAIL all4_rx%0d: got %h want %h", k, f_rx, tx[k]); else passes++;
      if (k > 0) begin
        checks++; if (f_pre !== 3 || f_idle_ok !== 1'b1) $display("FAIL all4_gap%0d: got %0d+1 cs-high cycles dclk_ok %0d want 3+1 and 1", k, f_pre, f_idle_ok); else passes++;
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_tied();
    miso_mode = 1;
    bus.req = 4'b0001;
    capture(0, '0, '0, 4'b0001);
    checks++; if (f_timeout !== 1'b0 || f_rx !== 16'hFFFF) $display("FAIL tied1_rx: got %h want ffff", f_rx); else passes++;
    checks++; if (f_cnt_ok !== 1'b1 || f_cnt_end !== '0) $display("FAIL tied1_cnt: steps_ok %0d end %0d want 1 and 0", f_cnt_ok, f_cnt_end); else passes++;
    repeat (8) @(negedge clk);
    miso_mode = 0;
    bus.req = 4'b0001;
    capture(0, '0, '0, 4'b0001);
    checks++; if (f_timeout !== 1'b0 || f_rx !== 16'h0000) $display("FAIL tied0_rx: got %h want 0000", f_rx); else passes++;
    checks++; if (f_cnt_ok !== 1'b1 || f_cnt_end !== '0) $display("FAIL tied0_cnt: steps_ok %0d end %0d want 1 and 0", f_cnt_ok, f_cnt_end); else passes++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int n;
    miso_mode = 2;
    bus.tx_data[2*FB +: FB] = 16'h3C5A;
    bus.req = 4'b0100;
    n = 0;
    while (bus.cs !== 1'b0 && n < 40) begin n++; @(negedge clk); end
    checks++; if (n >= 40 || bus.gnt !== 4'b0100) $display("FAIL rst_pre_gnt: got %b want 0100", bus.gnt); else passes++;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.cs, bus.dclk, bus.gnt, bus.busy} !== 7'b1100000) $display("FAIL rst_async: got %b want 1100000", {bus.cs, bus.dclk, bus.gnt, bus.busy}); else passes++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    capture(0, '0, '0, 4'b0100);
    checks++; if (f_timeout !== 1'b0 || f_gnt !== 4'b0100 || f_cs_low !== 66) $display("FAIL rst_restart: gnt %b cs_low %0d want 0100 66", f_gnt, f_cs_low); else passes++;
    checks++; if (f_mosi !== 16'h3C5A || f_rx !== 16'h3C5A) $display("FAIL rst_restart_data: mosi %h rx %h want 3c5a", f_mosi, f_rx); else passes++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_drop();
    miso_mode = 2;
    bus.tx_data[1*FB +: FB] = 16'h0F0F;
    bus.req = 4'b0010;
    capture(10, 4'b0010, 4'b0100, 4'b0000);
    checks++; if (f_timeout !== 1'b0 || f_cs_low !== 66 || f_gnt_ok !== 1'b1) $display("FAIL drop_len: cs_low %0d stable %0d want 66 1", f_cs_low, f_gnt_ok); else passes++;
    checks++; if (f_done !== 4'b0010 || f_rx !== 16'h0F0F) $display("FAIL drop_done: done %b rx %h want 0010 0f0f", f_done, f_rx); else passes++;
    capture(0, '0, '0, 4'b0100);
    checks++; if (f_timeout !== 1'b0 || f_gnt !== 4'b0100 || f_pre !== 3) $display("FAIL drop_next: gnt %b gap %0d+1 want 0100 3+1", f_gnt, f_pre); else passes++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] exp_g;
    do_reset();
    bus.req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0] ? 4'b1000 : 4'b0010;
      capture(0, '0, '0, (k == 3) ? 4'b1010 : 4'b0000);
      checks++; if (f_timeout !== 1'b0 || f_gnt !== exp_g || f_done !== exp_g) $display("FAIL b2b_gnt%0d: gnt %b done %b want %b", k, f_gnt, f_done, exp_g); else passes++;
      if (k > 0) begin
        checks++; if (f_busy_low !== 1 || f_pre !== 3) $display("FAIL b2b_idle%0d: busy_low %0d gap %0d+1 want 1 3+1", k, f_busy_low, f_pre); else passes++;
      end
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_tied();
    test_mid_reset();
    test_drop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_rr_master.md
Name: spi_rr_master

Overview:
Round-robin SPI master that shares one SPI bus (cs/dclk/mosi/miso) between NREQ requesters. Each requester asks for one fixed-length, full-duplex frame. The block arbitrates, generates cs and dclk with dclk idle-high, shifts data out MSB-first, captures miso and returns the received word. It sits between the client blocks and the external SPI device, and is the synchronous, resettable sequencer for the frame engine.

Parameters:
NREQ, 4, number of requesters (≥1)
FRAME_BITS, 16, bits per frame (≥2)
CLK_DIV, 2, clk cycles per dclk half-period (≥1)
GAP_CYC, 4, clk cycles cs stays high between frames (≥1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester frame request, level
tx_data  in  NREQ*FRAME_BITS  per-requester transmit word; slice i belongs to requester i
gnt  out  NREQ  one-hot grant, held for the whole frame
done  out  NREQ  one-cycle pulse to the granted requester at frame end
rx_data  out  FRAME_BITS  received word; valid when any done bit is high, held until the next done
busy  out  1  high from grant until the end of GAP
cs  out  1  chip select, active low
dclk  out  1  SPI clock, idle high
mosi  out  1  serial data out
miso  in  1  serial data in
cnt  out  $clog2(FRAME_BITS)  bits sampled so far in the current frame, mod FRAME_BITS

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values (applied immediately on rst_n low, including mid-frame): cs=1, dclk=1, mosi=0, gnt=0, done=0, rx_data=0, busy=0, cnt=0. Round-robin pointer = 0. State = IDLE.
- States: IDLE, SETUP, LOW, HIGH, GAP. The phase timer counts CLK_DIV cycles in SETUP/LOW/HIGH and GAP_CYC cycles in GAP.
- IDLE: when req≠0, select the first asserted req at or after the pointer, wrapping around.
  - Next edge: gnt=onehot(winner), busy=1, cs=0, dclk=1.
  - The shift register loads tx_data slice of the winner, and mosi takes its MSB.
  - Go to SETUP.
  - tx_data is sampled only at grant.
- SETUP: CLK_DIV cycles, then go to LOW with dclk=0.
- LOW: CLK_DIV cycles.
  - On entry (except the first LOW), mosi presents the next bit, MSB-first.
  - Exit to HIGH with dclk=1.
  - On this same edge, miso is shifted into the rx shift register LSB and cnt increments, wrapping to 0 after FRAME_BITS samples.
- HIGH: CLK_DIV cycles.
  - If fewer than FRAME_BITS bits have been sampled, go to LOW.
  - Otherwise, on the same edge:
    - cs=1
    - done[winner]=1 for one cycle
    - rx_data = shift register
    - gnt=0
    - pointer = (winner+1) mod NREQ
    - mosi=0
    - go to GAP.
- Frame timing: cs low for exactly (2*FRAME_BITS+1)*CLK_DIV cycles (66 with defaults). Exactly FRAME_BITS dclk rising edges per frame. dclk=1 whenever cs=1.
- GAP: cs=1 for GAP_CYC cycles. Then busy=0 and go to IDLE. A pending req is granted on the next edge.
- Dropping req mid-frame does not abort the frame. The frame completes and done still pulses. gnt never changes mid-frame.
- A continuously held req gets back-to-back frames separated by the gap; other pending requesters interleave by round-robin.
- NREQ=1 degenerates to a single client; pointer stays 0.

Decomposition:
- Shared package spi_pkg: state enum (IDLE, SETUP, LOW, HIGH, GAP) and default FRAME_BITS/CLK_DIV constants used by other SPI blocks.
- One natural sub-module, rr_arbiter (NREQ): inputs req and pointer; outputs one-hot winner and winner index; purely combinational.
- Shift, phase timer and FSM stay in spi_rr_master.

Test Plan:
1. req[0]=1, tx slice0=0xA5C3, miso looped to mosi -> cs low 66 cycles; 16 dclk rises; mosi sequence 1010_0101_1100_0011; done[0] single pulse; rx_data=0xA5C3; gnt=0001 throughout.
2. All four req asserted together after reset, held until own done -> grant order 0,1,2,3; cs high exactly 4 cycles between frames; each done pulse exactly once.
3. miso tied 1 then tied 0 -> rx_data 0xFFFF then 0x0000; cnt steps 0..15 and returns to 0 at frame end.
4. rst_n low 20 cycles into a frame for req2 -> cs=1, dclk=1, gnt=0, busy=0 with no clk edge; after release with req2 still high, the frame restarts from the MSB, granted by pointer 0 search.
5. req1 dropped at cycle 10 of its frame, req2 pending -> frame 1 completes full length with done[1]; req2 is granted after the gap.
6. req1 and req3 held high continuously -> grants alternate 1,3,1,3; no requester starved; busy high continuously except 1 IDLE cycle per frame.
